// File: rtl/bg_scene_ctrl_if.sv
// bg_scene_ctrl_if: scene-change request/acknowledge channel between the game FSM and the scene sequencer.
interface bg_scene_ctrl_if #(
  parameter int SEL_W = 3
);
  logic             scene_req;
  logic [SEL_W-1:0] scene_id;
  logic             scene_ack;
  logic             busy;
  logic             scene_done;
  modport master (output scene_req, scene_id, input scene_ack, busy, scene_done);
  modport slave (input scene_req, scene_id, output scene_ack, busy, scene_done);
endinterface

// File: rtl/bg_scene_ctrl.sv
// bg_scene_ctrl: frame-synchronous background scene sequencer (fade out, swap, fade in); define SCENE_QUEUE_EN for a one-deep request queue.
module bg_scene_ctrl #(
  parameter int NUM_SCENES      = 8,
  parameter int SEL_W           = 3,
  parameter int FRAMES_PER_STEP = 2,
  parameter int TICK_LINE       = 480,
  parameter int RESET_SCENE     = 0
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  input  logic [9:0]       DrawX,
  input  logic [9:0]       DrawY,
  input  logic             blank,
  bg_scene_ctrl_if.slave   scn,
  output logic [SEL_W-1:0] bg_sel,
  output logic [4:0]       fade_level,
  input  logic [3:0]       in_red,
  input  logic [3:0]       in_green,
  input  logic [3:0]       in_blue,
  output logic [3:0]       red,
  output logic [3:0]       green,
  output logic [3:0]       blue
);
  localparam int CW = FRAMES_PER_STEP > 1 ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FRAMES_PER_STEP - 1);
  typedef enum logic [1:0] {IDLE, FADE_OUT, SWAP, FADE_IN} state_t;
  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d, pend_q, pend_d;
  logic [4:0]       fade_q, fade_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ack_q, ack_d, done_q, done_d;
  logic [3:0]       red_q, green_q, blue_q;
  logic             tick, step, id_ok, accept;
`ifdef SCENE_QUEUE_EN
  logic             qv_q, qv_d;
  logic [SEL_W-1:0] qid_q, qid_d;
`endif
  function automatic logic [3:0] scale(input logic [3:0] c, input logic [4:0] f);
    logic [8:0] p;
    p = {5'd0, c} * {4'd0, f};
    return p[7:4];
  endfunction
  assign tick   = DrawX == 10'd0 && DrawY == 10'(TICK_LINE);
  assign step   = tick && cnt_q == CNT_MAX;
  assign id_ok  = int'(scn.scene_id) < NUM_SCENES;
  // the !ack_q guard keeps a still-held request from being accepted twice
  assign accept = scn.scene_req && !ack_q;
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sel_q   <= SEL_W'(RESET_SCENE);
      pend_q  <= '0;
      fade_q  <= 5'd16;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
`ifdef SCENE_QUEUE_EN
      qv_q    <= 1'b0;
      qid_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      pend_q  <= pend_d;
      fade_q  <= fade_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      red_q   <= blank ? scale(in_red, fade_q) : '0;
      green_q <= blank ? scale(in_green, fade_q) : '0;
      blue_q  <= blank ? scale(in_blue, fade_q) : '0;
`ifdef SCENE_QUEUE_EN
      qv_q    <= qv_d;
      qid_q   <= qid_d;
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    pend_d  = pend_q;
    fade_d  = fade_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    done_d  = 1'b0;
`ifdef SCENE_QUEUE_EN
    qv_d    = qv_q;
    qid_d   = qid_q;
    if (state_q != IDLE && accept && !qv_q) begin
      ack_d = 1'b1;
      qv_d  = id_ok;
      qid_d = scn.scene_id;
    end
`endif
    unique case (state_q)
      IDLE: begin
`ifdef SCENE_QUEUE_EN
        if (done_q && qv_q) begin
          qv_d = 1'b0;
          if (qid_q != sel_q) begin
            pend_d  = qid_q;
            state_d = FADE_OUT;
          end
        end else
`endif
        if (accept) begin
          ack_d = 1'b1;
          if (id_ok && scn.scene_id != sel_q) begin
            pend_d  = scn.scene_id;
            state_d = FADE_OUT;
          end
        end
      end
      FADE_OUT: if (tick) begin
        cnt_d  = step ? '0 : cnt_q + 1'b1;
        fade_d = step ? fade_q - 5'd1 : fade_q;
        if (step && fade_q == 5'd1) state_d = SWAP;
      end
      SWAP: if (tick) begin
        sel_d   = pend_q;
        cnt_d   = '0;
        state_d = FADE_IN;
      end
      FADE_IN: if (tick) begin
        cnt_d  = step ? '0 : cnt_q + 1'b1;
        fade_d = step ? fade_q + 5'd1 : fade_q;
        if (step && fade_q == 5'd15) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    scn.busy       = state_q != IDLE;
    scn.scene_ack  = ack_q;
    scn.scene_done = done_q;
    bg_sel         = sel_q;
    fade_level     = fade_q;
    red            = red_q;
    green          = green_q;
    blue           = blue_q;
  end
endmodule

// File: tb/tb_bg_scene_ctrl.sv
// tb_bg_scene_ctrl: directed plus randomized bench; the model tracks each transition as a tick count and derives fade/select arithmetically.
module tb_bg_scene_ctrl;
  localparam int F = 2, N = 8, RS = 2;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       reset_n, blank;
  logic [9:0] DrawX, DrawY;
  logic [3:0] in_r, in_g, in_b, red, green, blue;
  logic [2:0] bg_sel;
  logic [4:0] fade_level;
  bg_scene_ctrl_if #(.SEL_W(3)) scn ();
  bg_scene_ctrl #(.NUM_SCENES(N), .SEL_W(3), .FRAMES_PER_STEP(F), .TICK_LINE(480), .RESET_SCENE(RS)) dut (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank), .scn(scn),
    .bg_sel(bg_sel), .fade_level(fade_level), .in_red(in_r), .in_green(in_g), .in_blue(in_b),
    .red(red), .green(green), .blue(blue));
  int checks = 0, failures = 0;
  int m_t = 0, m_sel = RS, m_new = 0, qid = 0, e_r = 0, e_g = 0, e_b = 0;
  bit m_active = 0, m_ack = 0, m_done = 0, qv = 0;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic int mfade();
    if (!m_active) return 16;
    if (m_t <= 16 * F) return 16 - m_t / F;
    return (m_t - 16 * F - 1) / F;
  endfunction
  task automatic start(int id);
    m_active = 1;
    m_t = 0;
    m_new = id;
  endtask
  task automatic set_tick(bit t);
    DrawX = t ? 10'd0 : 10'($urandom_range(0, 1));
    DrawY = t ? 10'd480 : (DrawX == 10'd0 ? 10'd479 : 10'd480);
  endtask
  task automatic step();
    int pf;
    bit tk, na, nd;
    pf = mfade();
    tk = DrawX == 10'd0 && DrawY == 10'd480;
    @(posedge clk);
    na = 0;
    nd = 0;
    if (!reset_n) begin
      m_active = 0; m_t = 0; m_sel = RS; qv = 0;
      e_r = 0; e_g = 0; e_b = 0;
    end else begin
      e_r = blank ? (int'(in_r) * pf) / 16 : 0;
      e_g = blank ? (int'(in_g) * pf) / 16 : 0;
      e_b = blank ? (int'(in_b) * pf) / 16 : 0;
      if (m_active) begin
        if (tk) begin
          m_t++;
          if (m_t == 16 * F + 1) m_sel = m_new;
          if (m_t == 32 * F + 1) begin
            m_active = 0;
            nd = 1;
          end
        end
`ifdef SCENE_QUEUE_EN
        if (scn.scene_req && !m_ack && !qv) begin
          na = 1;
          if (int'(scn.scene_id) < N) begin
            qv = 1;
            qid = int'(scn.scene_id);
          end
        end
`endif
      end else begin
`ifdef SCENE_QUEUE_EN
        if (m_done && qv) begin
          qv = 0;
          if (qid != m_sel) start(qid);
        end else
`endif
        if (scn.scene_req && !m_ack) begin
          na = 1;
          if (int'(scn.scene_id) < N && int'(scn.scene_id) != m_sel) start(int'(scn.scene_id));
        end
      end
    end
    m_ack = na;
    m_done = nd;
    #1;
    chk("fade", fade_level, mfade());
    chk("sel", bg_sel, m_sel);
    chk("busy", scn.busy, m_active);
    chk("ack", scn.scene_ack, m_ack);
    chk("done", scn.scene_done, m_done);
    chk("red", red, e_r);
    chk("green", green, e_g);
    chk("blue", blue, e_b);
    if (scn.scene_req && m_ack) scn.scene_req = 1'b0;
  endtask
  task automatic wait_ack();
    int n = 0;
    while (!m_ack && n < 10) begin
      step();
      n++;
    end
    if (!m_ack) chk("ack_timeout", 0, 1);
  endtask
  task automatic run_xfer();
    int n = 0;
    while (m_active && n < 600) begin
      set_tick(n % 2 == 0);
      step();
      n++;
    end
    if (m_active) chk("xfer_timeout", 0, 1);
  endtask
  initial begin
    int n, nt, busy_acks;
    bit col, raised;
    reset_n = 1'b0; blank = 1'b0; in_r = 0; in_g = 0; in_b = 0;
    scn.scene_req = 1'b0; scn.scene_id = '0;
    set_tick(0);
    repeat (3) step();
    chk("rst_sel", bg_sel, 2);
    chk("rst_fade", fade_level, 16);
    chk("rst_busy", scn.busy, 0);
    chk("rst_rgb", {red, green, blue}, 0);
    reset_n = 1'b1;
    blank = 1'b1; in_r = 9; in_g = 5; in_b = 15;
    step();
    chk("pass_rgb", {red, green, blue}, {4'd9, 4'd5, 4'd15});
    blank = 1'b0;
    step();
    chk("blank_rgb", {red, green, blue}, 0);
    scn.scene_req = 1'b1; scn.scene_id = 3'd2;
    wait_ack();
    repeat (6) begin
      set_tick(1);
      step();
      chk("same_busy", scn.busy, 0);
      chk("same_fade", fade_level, 16);
    end
    blank = 1'b1; in_r = 15; in_g = 15; in_b = 15;
    set_tick(0);
    scn.scene_req = 1'b1; scn.scene_id = 3'd5;
    wait_ack();
    chk("xfer_busy", scn.busy, 1);
    nt = 0; n = 0; col = 0;
    while (m_active && n < 400) begin
      set_tick(n % 2 == 0);
      step();
      if (col) chk("col_f8", red, 7);
      col = 0;
      if (n % 2 == 0) begin
        nt++;
        if (nt == 16) begin chk("t16_fade", fade_level, 8); col = 1; end
        if (nt == 32) chk("t32_fade", fade_level, 0);
        if (nt == 33) chk("t33_sel", bg_sel, 5);
        if (nt == 65) begin
          chk("t65_fade", fade_level, 16);
          chk("t65_done", scn.scene_done, 1);
          chk("t65_busy", scn.busy, 0);
        end
      end
      n++;
    end
    if (m_active) chk("xfer_timeout", 0, 1);
    chk("xfer_ticks", nt, 65);
    scn.scene_req = 1'b1; scn.scene_id = 3'd1;
    set_tick(0);
    wait_ack();
    n = 0; busy_acks = 0; raised = 0;
    while (m_active && n < 400) begin
      set_tick(n % 2 == 0);
      step();
      if (raised && scn.scene_ack) busy_acks++;
      if (n == 8) begin
        scn.scene_req = 1'b1;
        scn.scene_id = 3'd3;
        raised = 1;
      end
      n++;
    end
`ifdef SCENE_QUEUE_EN
    chk("busy_acks", busy_acks, 1);
`else
    chk("busy_acks", busy_acks, 0);
`endif
    set_tick(0);
    step();
    chk("second_busy", scn.busy, 1);
    run_xfer();
    chk("second_sel", bg_sel, 3);
    scn.scene_req = 1'b1; scn.scene_id = 3'd6;
    set_tick(0);
    wait_ack();
    n = 0;
    while (!(m_active && m_t > 16 * F + 1 && mfade() == 9) && n < 400) begin
      set_tick(n % 2 == 0);
      step();
      n++;
    end
    chk("mid_fade9", fade_level, 9);
    reset_n = 1'b0;
    set_tick(0);
    step();
    chk("mid_rst_fade", fade_level, 16);
    chk("mid_rst_busy", scn.busy, 0);
    chk("mid_rst_sel", bg_sel, 2);
    reset_n = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      blank = 1'($urandom_range(0, 3) != 0);
      in_r = 4'($urandom); in_g = 4'($urandom); in_b = 4'($urandom);
      case ($urandom_range(0, 3))
        0: set_tick(1);
        1: set_tick(0);
        default: begin DrawX = 10'($urandom_range(0, 799)); DrawY = 10'($urandom_range(470, 490)); end
      endcase
      if (!scn.scene_req && $urandom_range(0, 29) == 0) begin
        scn.scene_req = 1'b1;
        scn.scene_id = 3'($urandom);
      end
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
